// File: rtl/dma_channel.sv
// dma_channel: single-channel DMA engine that copies a block of halfword or
// word units from a source to a destination address over the shared memory
// request bus. It arbitrates with the CPU via bus_req/bus_gnt and signals
// completion with a one-cycle done pulse (and irq when enabled).
//
// Ports:
//   clk, rst_n          system clock (rising edge), async active-low reset
//   cfg_src, cfg_dst    start addresses, sampled on start
//   cfg_cnt             unit count (0 means 2^CNT_W), sampled on start
//   cfg_src_ctl/dst_ctl address mode: 00 inc, 01 dec, 10 fixed, 11 inc
//   cfg_word            1 = 32-bit units, 0 = 16-bit units
//   cfg_irq_en          gate irq with done
//   start, abort        one-cycle trigger / stop request
//   busy, done, irq     status
//   bus_req, bus_gnt    bus arbitration handshake
//   mem_*               memory request interface (initiator side)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; config registers loaded on start
// S_REQ  | requesting the bus, waiting for bus_gnt (abort honoured here)
// S_RD   | read access at src; data latched on completion
// S_WR   | write access at dst; addresses/count stepped on completion
module dma_channel #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [CNT_W-1:0] cfg_cnt,
  input  logic [1:0]       cfg_src_ctl,
  input  logic [1:0]       cfg_dst_ctl,
  input  logic             cfg_word,
  input  logic             cfg_irq_en,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             irq,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic [1:0]       mem_width,
  output logic             mem_read,
  output logic             mem_write,
  input  logic             mem_ok
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RD, S_WR} state_t;

  localparam logic [CNT_W:0] REM_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t         state, state_nx;
  logic [31:0]    src, dst, data;
  logic [CNT_W:0] rem;
  logic [1:0]     src_ctl, dst_ctl;
  logic           word, irq_en;
  logic           abort_pend;
  logic           acc_first;
  logic           acc_done;
  logic           abort_now;
  logic           last_unit;

  // An access may only complete from its second cycle onward.
  assign acc_done  = ((state == S_RD) || (state == S_WR)) && !acc_first && mem_ok;
  assign abort_now = abort_pend || abort;
  assign last_unit = (rem == REM_ONE);

  function automatic logic [31:0] step_addr(input logic [31:0] a,
                                            input logic [1:0]  ctl,
                                            input logic        w);
    logic [31:0] sz;
    sz = w ? 32'd4 : 32'd2;
    case (ctl)
      2'b01:   step_addr = a - sz;
      2'b10:   step_addr = a;
      default: step_addr = a + sz;
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    busy      = (state != S_IDLE);
    bus_req   = (state != S_IDLE);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_width = word ? 2'd2 : 2'd1;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_REQ;
      end
      S_REQ: begin
        if (abort_now)    state_nx = S_IDLE;
        else if (bus_gnt) state_nx = S_RD;
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = src;
        if (acc_done) state_nx = S_WR;
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = dst;
        mem_wdata = word ? data : {data[15:0], data[15:0]};
        if (acc_done) begin
          if (last_unit || abort_now) state_nx = S_IDLE;
          else if (!bus_gnt)          state_nx = S_REQ;
          else                        state_nx = S_RD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      src        <= 32'h0;
      dst        <= 32'h0;
      data       <= 32'h0;
      rem        <= '0;
      src_ctl    <= 2'b00;
      dst_ctl    <= 2'b00;
      word       <= 1'b1;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
      acc_first  <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
    end else begin
      state     <= state_nx;
      done      <= 1'b0;
      irq       <= 1'b0;
      // Every entry into RD or WR is a fresh access.
      acc_first <= ((state_nx == S_RD) || (state_nx == S_WR)) && (state_nx != state);
      // Abort is only remembered while a transfer is in progress.
      abort_pend <= (state_nx != S_IDLE) && (abort_pend || (busy && abort));
      case (state)
        S_IDLE: begin
          if (start) begin
            src     <= cfg_word ? {cfg_src[31:2], 2'b00} : {cfg_src[31:1], 1'b0};
            dst     <= cfg_word ? {cfg_dst[31:2], 2'b00} : {cfg_dst[31:1], 1'b0};
            rem     <= (cfg_cnt == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, cfg_cnt};
            src_ctl <= cfg_src_ctl;
            dst_ctl <= cfg_dst_ctl;
            word    <= cfg_word;
            irq_en  <= cfg_irq_en;
          end
        end
        S_RD: begin
          if (acc_done) data <= word ? mem_rdata : {16'h0, mem_rdata[15:0]};
        end
        S_WR: begin
          if (acc_done) begin
            src <= step_addr(src, src_ctl, word);
            dst <= step_addr(dst, dst_ctl, word);
            rem <= rem - REM_ONE;
            if (last_unit) begin
              done <= 1'b1;
              irq  <= irq_en;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
